// File: rtl/video_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : video_mode_ctrl
// Description : Mode sequencer for the 74.25 MHz test-pattern timing generator.
//               Holds the active timing parameter set and drives the
//               generator's active-low reset. A mode change waits for the
//               active VS edge (or a timeout), then reloads the timing set
//               while the generator is held in reset, so a frame is never
//               cut short.
// Ports       : I_pxl_clk / I_rst      pixel clock, async active-high reset
//               I_mode_sel / I_mode_req mode request (sampled in IDLE only)
//               I_vs                   generator VS (polarity applied)
//               O_busy / O_mode_ack    handshake back to the requester
//               O_mode_cur             mode currently loaded
//               O_tp_rst_n             generator reset, active low
//               O_h_* / O_v_* / pols   timing parameter set
// Revision    : 1.0 - initial release
// ============================================================================
module video_mode_ctrl #(
  parameter logic [1:0] DEFAULT_MODE   = 2'd0,
  parameter int         RST_CYCLES     = 16,
  parameter int         TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        I_pxl_clk,
  input  logic        I_rst,
  input  logic [1:0]  I_mode_sel,
  input  logic        I_mode_req,
  input  logic        I_vs,
  output logic        O_busy,
  output logic        O_mode_ack,
  output logic [1:0]  O_mode_cur,
  output logic        O_tp_rst_n,
  output logic [11:0] O_h_total,
  output logic [11:0] O_h_sync,
  output logic [11:0] O_h_bporch,
  output logic [11:0] O_h_res,
  output logic [11:0] O_v_total,
  output logic [11:0] O_v_sync,
  output logic [11:0] O_v_bporch,
  output logic [11:0] O_v_res,
  output logic        O_hs_pol,
  output logic        O_vs_pol
);

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_IDLE    = 3'd1,
    S_WAIT_VS = 3'd2,
    S_BLANK   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_bporch;
    logic [11:0] h_res;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_bporch;
    logic [11:0] v_res;
    logic        hs_pol;
    logic        vs_pol;
  } timing_t;

  function automatic timing_t f_mode_lut(input logic [1:0] mode);
    timing_t t;
    case (mode)
      2'd0:    t = '{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 1'b1, 1'b1};
      2'd1:    t = '{12'd800,  12'd96,  12'd48,  12'd640,  12'd525, 12'd2, 12'd33, 12'd480, 1'b0, 1'b0};
      2'd2:    t = '{12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600, 1'b1, 1'b1};
      default: t = '{12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768, 1'b0, 1'b0};
    endcase
    return t;
  endfunction

  localparam timing_t     c_DEF_TIMING = f_mode_lut(DEFAULT_MODE);
  localparam logic [20:0] c_RST_LAST   = 21'(RST_CYCLES - 1);
  localparam logic [20:0] c_TO_LAST    = 21'(TIMEOUT_CYCLES - 1);
  localparam logic [20:0] c_CNT_MAX    = '1;

  state_t      r_state;
  timing_t     r_tim;
  logic [1:0]  r_mode_cur;
  logic [1:0]  r_pend;
  logic        r_tp_rst_n;
  logic        r_busy;
  logic        r_ack;
  logic [20:0] r_cnt;
  logic        r_vs_d;

  logic        w_vs_edge;
  logic [20:0] w_cnt_inc;

  // Active edge: input reaches the current mode's active level from the
  // inactive one. r_vs_d tracks I_vs continuously so the first WAIT_VS cycle
  // never compares against a stale sample.
  assign w_vs_edge = (I_vs == r_tim.vs_pol) && (r_vs_d != r_tim.vs_pol);
  assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 21'd1;

  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state    <= S_BOOT;
      r_tim      <= c_DEF_TIMING;
      r_mode_cur <= DEFAULT_MODE;
      r_pend     <= DEFAULT_MODE;
      r_tp_rst_n <= 1'b0;
      r_busy     <= 1'b1;
      r_ack      <= 1'b0;
      r_cnt      <= '0;
      r_vs_d     <= 1'b0;
    end else begin
      r_vs_d <= I_vs;
      r_ack  <= 1'b0;
      r_cnt  <= w_cnt_inc;
      case (r_state)
        S_BOOT: begin
          if (r_cnt == c_RST_LAST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_tp_rst_n <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        S_IDLE: begin
          if (I_mode_req) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            if (I_mode_sel == r_mode_cur) begin
              // Already running: acknowledge without touching the generator.
              r_state <= S_DONE;
              r_ack   <= 1'b1;
            end else begin
              r_pend  <= I_mode_sel;
              r_state <= S_WAIT_VS;
            end
          end
        end
        S_WAIT_VS: begin
          // Timeout covers a stuck or absent VS so a request cannot hang.
          if (w_vs_edge || (r_cnt == c_TO_LAST)) begin
            r_state    <= S_BLANK;
            r_cnt      <= '0;
            r_tp_rst_n <= 1'b0;
            r_tim      <= f_mode_lut(r_pend);
            r_mode_cur <= r_pend;
          end
        end
        S_BLANK: begin
          if (r_cnt == c_RST_LAST) begin
            r_state    <= S_DONE;
            r_cnt      <= '0;
            r_tp_rst_n <= 1'b1;
            r_ack      <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_BOOT;
          r_cnt      <= '0;
          r_tp_rst_n <= 1'b0;
          r_busy     <= 1'b1;
        end
      endcase
    end
  end

  assign O_busy     = r_busy;
  assign O_mode_ack = r_ack;
  assign O_mode_cur = r_mode_cur;
  assign O_tp_rst_n = r_tp_rst_n;
  assign O_h_total  = r_tim.h_total;
  assign O_h_sync   = r_tim.h_sync;
  assign O_h_bporch = r_tim.h_bporch;
  assign O_h_res    = r_tim.h_res;
  assign O_v_total  = r_tim.v_total;
  assign O_v_sync   = r_tim.v_sync;
  assign O_v_bporch = r_tim.v_bporch;
  assign O_v_res    = r_tim.v_res;
  assign O_hs_pol   = r_tim.hs_pol;
  assign O_vs_pol   = r_tim.vs_pol;

endmodule
`default_nettype wire

// File: tb/tb_video_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_mode_ctrl
// Description : Self-checking bench for video_mode_ctrl. Accepted requests push
//               the expected mode into a scoreboard queue; every ack pops and
//               compares mode and full timing set against a reference table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_mode_ctrl;

  localparam int RST_CYC = 16;
  localparam int TO_CYC  = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode_sel;
  logic        mode_req;
  logic        vs;
  logic        busy;
  logic        mode_ack;
  logic [1:0]  mode_cur;
  logic        tp_rst_n;
  logic [11:0] h_total, h_sync, h_bporch, h_res;
  logic [11:0] v_total, v_sync, v_bporch, v_res;
  logic        hs_pol, vs_pol;

  int checks = 0;
  int errors = 0;
  logic [1:0] sb_q[$];

  always #5 clk = ~clk;

  video_mode_ctrl #(
    .DEFAULT_MODE   (2'd0),
    .RST_CYCLES     (RST_CYC),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .I_pxl_clk  (clk),
    .I_rst      (rst),
    .I_mode_sel (mode_sel),
    .I_mode_req (mode_req),
    .I_vs       (vs),
    .O_busy     (busy),
    .O_mode_ack (mode_ack),
    .O_mode_cur (mode_cur),
    .O_tp_rst_n (tp_rst_n),
    .O_h_total  (h_total),
    .O_h_sync   (h_sync),
    .O_h_bporch (h_bporch),
    .O_h_res    (h_res),
    .O_v_total  (v_total),
    .O_v_sync   (v_sync),
    .O_v_bporch (v_bporch),
    .O_v_res    (v_res),
    .O_hs_pol   (hs_pol),
    .O_vs_pol   (vs_pol)
  );

  logic [97:0] dut_tim;
  assign dut_tim = {h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res, hs_pol, vs_pol};

  function automatic logic [97:0] exp_tim(input logic [1:0] m);
    logic [97:0] t;
    case (m)
      2'd0:    t = {12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 1'b1, 1'b1};
      2'd1:    t = {12'd800,  12'd96,  12'd48,  12'd640,  12'd525, 12'd2, 12'd33, 12'd480, 1'b0, 1'b0};
      2'd2:    t = {12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600, 1'b1, 1'b1};
      default: t = {12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768, 1'b0, 1'b0};
    endcase
    return t;
  endfunction

  // Scoreboard consumer: every ack must match the oldest outstanding request.
  always @(negedge clk) begin
    logic [1:0] exp_m;
    if (mode_ack === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got ack with mode_cur=%0d, expected no ack", mode_cur);
      end else begin
        exp_m = sb_q.pop_front();
        if (mode_cur !== exp_m || dut_tim !== exp_tim(exp_m) || tp_rst_n !== 1'b1) begin
          errors++;
          $display("FAIL ack_compare: mode_cur=%0d tim=%h tp_rst_n=%b, expected mode=%0d tim=%h tp_rst_n=1",
                   mode_cur, dut_tim, tp_rst_n, exp_m, exp_tim(exp_m));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tp(input logic lvl, input int limit, output int n);
    n = 0;
    while (tp_rst_n !== lvl && n < limit) begin
      step(1);
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1; mode_sel = 2'd0; mode_req = 1'b0; vs = 1'b0;
    step(3);
    checks++;
    if (tp_rst_n !== 1'b0 || busy !== 1'b1 || mode_ack !== 1'b0 || mode_cur !== 2'd0 || dut_tim !== exp_tim(2'd0)) begin
      errors++;
      $display("FAIL reset_state: tp_rst_n=%b busy=%b ack=%b mode=%0d tim=%h, expected 0 1 0 0 %h",
               tp_rst_n, busy, mode_ack, mode_cur, dut_tim, exp_tim(2'd0));
    end
    rst = 1'b0;
    wait_tp(1'b1, 200, n);
    checks++;
    if (n !== RST_CYC) begin
      errors++;
      $display("FAIL boot_len: tp_rst_n low %0d cycles, expected %0d", n, RST_CYC);
    end
    checks++;
    if (busy !== 1'b0 || mode_cur !== 2'd0 || dut_tim !== exp_tim(2'd0)) begin
      errors++;
      $display("FAIL boot_idle: busy=%b mode=%0d tim=%h, expected busy=0 mode=0 tim=%h",
               busy, mode_cur, dut_tim, exp_tim(2'd0));
    end
  endtask

  task automatic test_mode_change;
    int n;
    mode_sel = 2'd1; mode_req = 1'b1;
    sb_q.push_back(2'd1);
    step(1);
    mode_req = 1'b0;
    step(3);
    checks++;
    if (busy !== 1'b1 || tp_rst_n !== 1'b1 || mode_cur !== 2'd0) begin
      errors++;
      $display("FAIL wait_vs_hold: busy=%b tp_rst_n=%b mode=%0d, expected 1 1 0", busy, tp_rst_n, mode_cur);
    end
    vs = 1'b1;
    step(1);
    checks++;
    if (tp_rst_n !== 1'b0 || mode_cur !== 2'd1 || dut_tim !== exp_tim(2'd1)) begin
      errors++;
      $display("FAIL blank_load: tp_rst_n=%b mode=%0d tim=%h, expected 0 1 %h", tp_rst_n, mode_cur, dut_tim, exp_tim(2'd1));
    end
    wait_tp(1'b1, 100, n);
    checks++;
    if (n !== RST_CYC || mode_ack !== 1'b1) begin
      errors++;
      $display("FAIL blank_len: low %0d cycles ack=%b, expected %0d cycles ack=1", n, mode_ack, RST_CYC);
    end
    step(1);
    checks++;
    if (mode_ack !== 1'b0 || busy !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL change_done: ack=%b busy=%b pending=%0d, expected 0 0 0", mode_ack, busy, sb_q.size());
    end
  endtask

  task automatic test_same_mode;
    mode_sel = 2'd1; mode_req = 1'b1;
    sb_q.push_back(2'd1);
    step(1);
    mode_req = 1'b0;
    checks++;
    if (mode_ack !== 1'b1 || tp_rst_n !== 1'b1 || busy !== 1'b1 || dut_tim !== exp_tim(2'd1)) begin
      errors++;
      $display("FAIL same_mode_ack: ack=%b tp_rst_n=%b busy=%b tim=%h, expected 1 1 1 %h",
               mode_ack, tp_rst_n, busy, dut_tim, exp_tim(2'd1));
    end
    step(1);
    checks++;
    if (mode_ack !== 1'b0 || busy !== 1'b0 || tp_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL same_mode_idle: ack=%b busy=%b tp_rst_n=%b, expected 0 0 1", mode_ack, busy, tp_rst_n);
    end
  endtask

  task automatic test_timeout;
    int n;
    mode_sel = 2'd3; mode_req = 1'b1;
    sb_q.push_back(2'd3);
    step(1);
    mode_req = 1'b0;
    wait_tp(1'b0, 300, n);
    checks++;
    if (n !== TO_CYC || mode_cur !== 2'd3 || h_total !== 12'd1344) begin
      errors++;
      $display("FAIL timeout: blank after %0d cycles mode=%0d h_total=%0d, expected %0d 3 1344", n, mode_cur, h_total, TO_CYC);
    end
    wait_tp(1'b1, 100, n);
    step(1);
    checks++;
    if (n !== RST_CYC || busy !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_done: low %0d busy=%b pending=%0d, expected %0d 0 0", n, busy, sb_q.size(), RST_CYC);
    end
  endtask

  task automatic test_busy_ignore;
    int n;
    mode_sel = 2'd0; mode_req = 1'b1;
    sb_q.push_back(2'd0);
    step(1);
    mode_sel = 2'd2;
    step(2);
    vs = 1'b0;
    step(1);
    step(2);
    mode_req = 1'b0;
    checks++;
    if (mode_cur !== 2'd0 || tp_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL busy_blank: mode=%0d tp_rst_n=%b, expected 0 0", mode_cur, tp_rst_n);
    end
    wait_tp(1'b1, 100, n);
    step(3);
    checks++;
    if (mode_cur !== 2'd0 || busy !== 1'b0 || dut_tim !== exp_tim(2'd0) || sb_q.size() != 0) begin
      errors++;
      $display("FAIL busy_ignore: mode=%0d busy=%b pending=%0d, expected mode 0 busy 0 pending 0", mode_cur, busy, sb_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int n;
    mode_sel = 2'd1; mode_req = 1'b1;
    step(1);
    mode_req = 1'b0;
    vs = 1'b1;
    step(1);
    checks++;
    if (mode_cur !== 2'd1 || tp_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL mid_blank: mode=%0d tp_rst_n=%b, expected 1 0", mode_cur, tp_rst_n);
    end
    step(3);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mode_cur !== 2'd0 || dut_tim !== exp_tim(2'd0) || tp_rst_n !== 1'b0 || busy !== 1'b1 || mode_ack !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: mode=%0d tim=%h tp_rst_n=%b busy=%b ack=%b, expected 0 %h 0 1 0",
               mode_cur, dut_tim, tp_rst_n, busy, mode_ack, exp_tim(2'd0));
    end
    step(2);
    rst = 1'b0;
    wait_tp(1'b1, 200, n);
    step(2);
    checks++;
    if (n !== RST_CYC || busy !== 1'b0 || mode_cur !== 2'd0) begin
      errors++;
      $display("FAIL reboot: low %0d busy=%b mode=%0d, expected %0d 0 0", n, busy, mode_cur, RST_CYC);
    end
  endtask

  initial begin
    test_reset();
    test_mode_change();
    test_same_mode();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
